// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: protocol bytes, event layout, FSM encodings, default keymap.
package ps2_pkg;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E1 = 8'hE1;
    localparam logic [7:0] BYTE_AA = 8'hAA;
    localparam logic [7:0] BYTE_FA = 8'hFA;
    localparam logic [7:0] BYTE_EE = 8'hEE;
    localparam logic [7:0] BYTE_FE = 8'hFE;
    localparam logic [7:0] BYTE_FF = 8'hFF;
    localparam logic [7:0] BYTE_00 = 8'h00;
    localparam logic [7:0] BYTE_FC = 8'hFC;

    localparam int unsigned EV_W        = 10;
    localparam int unsigned EV_CODE_LSB = 0;
    localparam int unsigned EV_BRK_BIT  = 8;
    localparam int unsigned EV_EXT_BIT  = 9;

    localparam int unsigned KEYMAP_ENTRY_W = 9;
    localparam int unsigned GBA_NUM_KEYS   = 10;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    typedef enum logic [1:0] {D_BASE, D_EXT, D_BRK, D_EXT_BRK} dec_state_t;
    typedef enum logic {RX_IDLE, RX_BITS} rx_state_t;

    // Entry i = {ext, code}; order J,K,N,M,D,A,W,S,I,U from entry 0 upward.
    localparam logic [GBA_NUM_KEYS*KEYMAP_ENTRY_W-1:0] GBA_KEYMAP = {
        9'h03C, 9'h043, 9'h01B, 9'h01D, 9'h01C,
        9'h023, 9'h03A, 9'h031, 9'h042, 9'h03B
    };

    // Bytes that carry no key meaning and reset the prefix decoder.
    function automatic logic is_dropped_byte(input logic [7:0] b);
        return b inside {BYTE_E1, BYTE_00, BYTE_AA, BYTE_EE, BYTE_FA, BYTE_FC, BYTE_FE, BYTE_FF};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronisers, falling-edge strobe, 11-bit frame FSM, watchdog.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       frame_err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    logic [2:0]      clk_sync, data_sync;
    logic            strobe, bit_in;
    rx_state_t       state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [8:0]      shift_q, shift_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic [7:0]      byte_d;
    logic            byte_stb_d, frame_err_d;

    // Three-flop synchronisers; idle-high line level on reset.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync  <= 3'b111;
            data_sync <= 3'b111;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[1:0], ps2_data};
        end
    end

    assign strobe = clk_sync[2] & ~clk_sync[1];
    assign bit_in = data_sync[2];

    // Frame state and datapath registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= RX_IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 9'd0;
            wdog_q    <= '0;
            rx_byte   <= 8'd0;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            wdog_q    <= wdog_d;
            rx_byte   <= byte_d;
            byte_stb  <= byte_stb_d;
            frame_err <= frame_err_d;
        end
    end

    // Next-state: start bit, 8 data LSB first, parity, stop; watchdog aborts stalled frames.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_d      = rx_byte;
        byte_stb_d  = 1'b0;
        frame_err_d = 1'b0;
        wdog_d      = '0;
        case (state_q)
            RX_IDLE: begin
                if (strobe && !bit_in) begin
                    state_d   = RX_BITS;
                    bit_cnt_d = 4'd0;
                end
            end
            RX_BITS: begin
                if (strobe) begin
                    if (bit_cnt_q == 4'd9) begin
                        state_d = RX_IDLE;
                        if (bit_in && (^shift_q)) begin
                            byte_d     = shift_q[7:0];
                            byte_stb_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        shift_d   = {bit_in, shift_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (wdog_q == WD_LIMIT) begin
                    state_d     = RX_IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder: prefix decode, held-key bitmap against a run-time keymap, event FIFO.
// Build option PS2_TYPEMATIC_FILTER_EN suppresses repeated makes of keys already held.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_AW        = 3,
    parameter int unsigned NUM_KEYS       = 10,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                               clk,
    input  logic                               clrn,
    input  logic                               ps2_clk,
    input  logic                               ps2_data,
    input  logic [NUM_KEYS*KEYMAP_ENTRY_W-1:0] keymap,
    output logic [NUM_KEYS-1:0]                keys_down,
    output logic                               ev_valid,
    input  logic                               ev_ready,
    output logic [7:0]                         ev_code,
    output logic                               ev_ext,
    output logic                               ev_brk,
    output logic                               overflow,
    output logic                               frame_err
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned PTR_W = FIFO_AW + 1;

    logic [7:0]          rx_byte;
    logic                rx_stb;
    dec_state_t          dec_q, dec_d;
    logic                ev_push_q, ev_push_d;
    ps2_event_t          ev_q, ev_d;
    logic [NUM_KEYS-1:0] key_match;
    logic                repeat_c, accept;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic                fifo_empty, fifo_full, pop, push;
    ps2_event_t          mem [DEPTH];
    ps2_event_t          head;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .clrn     (clrn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .byte_stb (rx_stb),
        .frame_err(frame_err)
    );

    // Decode state and registered event request.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            dec_q     <= D_BASE;
            ev_push_q <= 1'b0;
            ev_q      <= '0;
        end else begin
            dec_q     <= dec_d;
            ev_push_q <= ev_push_d;
            ev_q      <= ev_d;
        end
    end

    // Prefix decoder: E0/F0 accumulate, noise bytes reset, anything else emits an event.
    always_comb begin
        dec_d     = dec_q;
        ev_push_d = 1'b0;
        ev_d      = ev_q;
        if (frame_err) begin
            dec_d = D_BASE;
        end else if (rx_stb) begin
            if (rx_byte == BYTE_E0) begin
                dec_d = D_EXT;
            end else if (rx_byte == BYTE_F0) begin
                if (dec_q == D_BASE)     dec_d = D_BRK;
                else if (dec_q == D_EXT) dec_d = D_EXT_BRK;
            end else if (is_dropped_byte(rx_byte)) begin
                dec_d = D_BASE;
            end else begin
                ev_push_d = 1'b1;
                ev_d.ext  = (dec_q == D_EXT) || (dec_q == D_EXT_BRK);
                ev_d.brk  = (dec_q == D_BRK) || (dec_q == D_EXT_BRK);
                ev_d.code = rx_byte;
                dec_d     = D_BASE;
            end
        end
    end

    // Keymap lookup for the pending event; duplicate entries all match.
    always_comb begin
        key_match = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            key_match[i] = (keymap[KEYMAP_ENTRY_W*i +: KEYMAP_ENTRY_W] == {ev_q.ext, ev_q.code});
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign repeat_c = ~ev_q.brk & (|(key_match & keys_down));
`else
    assign repeat_c = 1'b0;
`endif

    assign accept = ev_push_q & ~repeat_c;

    // Held-key bitmap: make sets, break clears every matching entry.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            keys_down <= '0;
        end else if (accept) begin
            keys_down <= ev_q.brk ? (keys_down & ~key_match) : (keys_down | key_match);
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop        = ~fifo_empty & ev_ready;
    assign push       = accept & (~fifo_full | pop);

    // FIFO pointers and sticky drop flag.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (accept && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    // FIFO storage; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= ev_q;
    end

    assign head     = mem[rd_ptr[FIFO_AW-1:0]];
    assign ev_valid = ~fifo_empty;
    assign ev_code  = head.code;
    assign ev_ext   = head.ext;
    assign ev_brk   = head.brk;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: PS/2 frame driver, event-level model, decoupled monitor.
`timescale 1ns/1ps
module tb_ps2_key_decoder;
    import ps2_pkg::*;

    localparam int unsigned FIFO_AW        = 2;
    localparam int unsigned NUM_KEYS       = 10;
    localparam int unsigned TIMEOUT_CYCLES = 200;
    localparam int unsigned HALF           = 8;

    logic clk = 1'b0;
    logic clrn = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic ev_ready = 1'b0;
    logic [NUM_KEYS*9-1:0] keymap;
    logic [NUM_KEYS-1:0]   keys_down;
    logic                  ev_valid, ev_ext, ev_brk, overflow, frame_err;
    logic [7:0]            ev_code;

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .FIFO_AW(FIFO_AW), .NUM_KEYS(NUM_KEYS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keymap(keymap), .keys_down(keys_down), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_brk(ev_brk),
        .overflow(overflow), .frame_err(frame_err)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [9:0] exp_q[$];
    logic [NUM_KEYS-1:0] model_keys = '0;
    int fe_count = 0;
    int fe_long = 0;
    logic fe_prev = 1'b0;
    int ready_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] pack_ev(input logic ext, input logic brk, input logic [7:0] code);
        logic [9:0] w;
        w = '0;
        w[EV_EXT_BIT] = ext;
        w[EV_BRK_BIT] = brk;
        w[EV_CODE_LSB +: 8] = code;
        return w;
    endfunction

    function automatic logic [NUM_KEYS-1:0] match_of(input logic ext, input logic [7:0] code);
        logic [NUM_KEYS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_KEYS; i++) m[i] = (keymap[9*i +: 9] == {ext, code});
        return m;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive the first nbits of a start/data/parity/stop frame.
    task automatic ps2_bits(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            tick(HALF);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        tick(HALF);
        ps2_data = 1'b1;
        tick(12);
    endtask

    // One key event: model effect on bitmap/queue, then bytes on the wire.
    task automatic send_event(input logic ext, input logic brk, input logic [7:0] code, input bit queued);
        logic [NUM_KEYS-1:0] m;
        bit suppress;
        m = match_of(ext, code);
        suppress = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        suppress = !brk && ((m & model_keys) != '0);
`endif
        if (!suppress) begin
            if (queued) exp_q.push_back(pack_ev(ext, brk, code));
            model_keys = brk ? (model_keys & ~m) : (model_keys | m);
        end
        if (ext) ps2_bits(8'hE0, 1'b0, 11);
        if (brk) ps2_bits(8'hF0, 1'b0, 11);
        ps2_bits(code, 1'b0, 11);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ev_valid) && n < 500) begin
            tick(1);
            n++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("drain_fifo_empty", 32'(ev_valid), 32'd0);
    endtask

    // Consumer ready policy: 0 hold off, 1 random, 2 always, 3 pop exactly when a push lands.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ev_ready = 1'b0;
                1:       ev_ready = ($urandom_range(0, 3) != 0);
                2:       ev_ready = 1'b1;
                default: ev_ready = dut.ev_push_q;
            endcase
        end
    end

    // Monitor: pops expected events as the DUT hands them over; tracks frame_err pulses.
    always @(negedge clk) begin
        logic [9:0] e;
        if (clrn) begin
            if (frame_err) begin
                fe_count++;
                if (fe_prev) fe_long++;
            end
            fe_prev = frame_err;
            if (ev_valid && ev_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got 0x%0h expected none at %0t",
                             pack_ev(ev_ext, ev_brk, ev_code), $time);
                end else begin
                    e = exp_q.pop_front();
                    check("event", 32'(pack_ev(ev_ext, ev_brk, ev_code)), 32'(e));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int fe0;
        logic [NUM_KEYS-1:0] k0;
        logic [7:0] unmapped [4];
        logic [7:0] ov_codes [5];
        int idx;
        logic ext, brk;
        logic [7:0] code;

        unmapped = '{8'h15, 8'h2C, 8'h4D, 8'h74};
        ov_codes = '{8'h15, 8'h2C, 8'h4D, 8'h74, 8'h16};
        keymap = {9'h03C, 9'h043, 9'h01B, 9'h01D, 9'h01C,
                  9'h023, 9'h03A, 9'h031, 9'h042, 9'h03B};

        clrn = 1'b0;
        tick(5);
        check("rst_keys_down", 32'(keys_down), 32'd0);
        check("rst_ev_valid", 32'(ev_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        clrn = 1'b1;
        tick(5);
        ready_mode = 1;

        // Plain make then break of A.
        send_event(1'b0, 1'b0, 8'h1C, 1'b1);
        check("make_1c_key5", 32'(keys_down[5]), 32'd1);
        send_event(1'b0, 1'b1, 8'h1C, 1'b1);
        check("break_1c_key5", 32'(keys_down[5]), 32'd0);

        // Extended key mapped to entry 6.
        keymap[6*9 +: 9] = 9'h175;
        send_event(1'b1, 1'b0, 8'h75, 1'b1);
        check("ext_make_key6", 32'(keys_down[6]), 32'd1);
        send_event(1'b0, 1'b0, 8'h75, 1'b1);
        check("plain75_key6_held", 32'(keys_down[6]), 32'd1);
        send_event(1'b1, 1'b1, 8'h75, 1'b1);
        check("ext_break_key6", 32'(keys_down[6]), 32'd0);
        send_event(1'b0, 1'b0, 8'h75, 1'b1);
        check("plain75_key6_clear", 32'(keys_down[6]), 32'd0);

        // Bad parity frame is rejected, next good frame accepted.
        fe0 = fe_count;
        k0 = keys_down;
        ps2_bits(8'h3B, 1'b1, 11);
        check("parity_frame_err", 32'(fe_count), 32'(fe0 + 1));
        check("parity_keys_same", 32'(keys_down), 32'(k0));
        send_event(1'b0, 1'b0, 8'h3B, 1'b1);
        check("after_parity_key0", 32'(keys_down[0]), 32'd1);
        send_event(1'b0, 1'b1, 8'h3B, 1'b1);
        check("after_parity_key0_rel", 32'(keys_down[0]), 32'd0);

        // Stalled frame aborts after the watchdog interval.
        fe0 = fe_count;
        ps2_bits(8'h23, 1'b0, 5);
        tick(TIMEOUT_CYCLES + 50);
        check("timeout_frame_err", 32'(fe_count), 32'(fe0 + 1));
        send_event(1'b0, 1'b0, 8'h23, 1'b1);
        check("after_timeout_key4", 32'(keys_down[4]), 32'd1);
        send_event(1'b0, 1'b1, 8'h23, 1'b1);
        check("after_timeout_key4_rel", 32'(keys_down[4]), 32'd0);

        // Typematic repeats of J.
        for (int i = 0; i < 3; i++) send_event(1'b0, 1'b0, 8'h3B, 1'b1);
        check("typematic_key0", 32'(keys_down[0]), 32'd1);
        drain();
        send_event(1'b0, 1'b1, 8'h3B, 1'b1);

        // Randomised traffic, with a duplicate J entry at 7.
        keymap[7*9 +: 9] = 9'h03B;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 5) < 4) begin
                idx  = int'($urandom_range(0, NUM_KEYS - 1));
                ext  = keymap[9*idx + 8];
                code = keymap[9*idx +: 8];
            end else begin
                idx  = int'($urandom_range(0, 3));
                ext  = 1'($urandom_range(0, 1));
                code = unmapped[idx];
            end
            brk = 1'($urandom_range(0, 1));
            send_event(ext, brk, code, 1'b1);
            check("rand_keys_down", 32'(keys_down), 32'(model_keys));
        end
        drain();
        check("no_overflow_yet", 32'(overflow), 32'd0);

        // Overflow: 5 makes into a 4-deep FIFO, then pop and push together.
        ready_mode = 0;
        tick(2);
        for (int i = 0; i < 5; i++) send_event(1'b0, 1'b0, ov_codes[i], i < 4);
        check("overflow_set", 32'(overflow), 32'd1);
        check("overflow_valid", 32'(ev_valid), 32'd1);
        ready_mode = 3;
        send_event(1'b0, 1'b0, 8'h2E, 1'b1);
        ready_mode = 1;
        drain();
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Reset in the middle of a frame with keys held.
        send_event(1'b0, 1'b0, 8'h42, 1'b1);
        check("pre_reset_key1", 32'(keys_down[1]), 32'd1);
        drain();
        ps2_bits(8'h43, 1'b0, 6);
        clrn = 1'b0;
        exp_q.delete();
        model_keys = '0;
        tick(3);
        check("midrst_keys_down", 32'(keys_down), 32'd0);
        check("midrst_ev_valid", 32'(ev_valid), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        clrn = 1'b1;
        tick(5);
        send_event(1'b0, 1'b0, 8'h43, 1'b1);
        check("post_reset_keys", 32'(keys_down), 32'(model_keys));
        drain();
        check("frame_err_one_cycle", 32'(fe_long), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
